// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, combinational ROM address,
// jump redirect with a single bubble, stall hold, and halt after the last program address.
module if_stage #(
    parameter logic [3:0]  RESET_PC  = 4'h0,
    parameter logic [3:0]  LAST_ADDR = 4'hF,
    parameter bit          HALT_EN   = 1'b1,
    parameter logic [15:0] NOP_INST  = 16'h0000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             jump_en_i,
    input  logic [3:0]       jump_addr_i,
    output logic [3:0]       rom_addr_o,
    input  logic [15:0]      rom_inst_i,
    output logic [15:0]      inst_o,
    output logic [3:0]       inst_addr_o,
    output logic             valid_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         pc_q, pc_d;
    logic [15:0]        inst_q, inst_d;
    logic [3:0]         addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Jump outranks stall so a redirect is never lost behind a decode hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (jump_en_i) begin
            pc_d    = jump_addr_i;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            addr_d  = pc_q;
            state_d = ST_RUN;
        end else if (!stall_i) begin
            addr_d = pc_q;
            if (state_q == ST_RUN) begin
                inst_d  = rom_inst_i;
                valid_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (HALT_EN && (pc_q == LAST_ADDR)) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + 4'd1;
                end
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            addr_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr_o  = pc_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = addr_q;
    assign valid_o     = valid_q;
    assign halt_o      = (state_q == ST_HALT);
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: default, LAST_ADDR=5 and HALT_EN=0 instances share stimulus;
// each directed step queues its hand-computed post-edge outputs for the monitor.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jen;
    logic [3:0]  jaddr;

    logic [3:0]  rom0, rom1, rom2;
    logic [15:0] rinst0, rinst1, rinst2;
    logic [15:0] inst0, inst1, inst2;
    logic [3:0]  addr0, addr1, addr2;
    logic        val0, val1, val2;
    logic        halt0, halt1, halt2;
    logic [7:0]  cnt0, cnt1, cnt2;

    assign rinst0 = 16'hA000 | {12'h000, rom0};
    assign rinst1 = 16'hA000 | {12'h000, rom1};
    assign rinst2 = 16'hA000 | {12'h000, rom2};

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(4'h0), .LAST_ADDR(4'hF), .HALT_EN(1'b1), .NOP_INST(16'h0000), .CNT_W(8)) u_dflt (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_en_i(jen), .jump_addr_i(jaddr),
        .rom_addr_o(rom0), .rom_inst_i(rinst0), .inst_o(inst0), .inst_addr_o(addr0),
        .valid_o(val0), .halt_o(halt0), .fetch_cnt_o(cnt0)
    );

    if_stage #(.RESET_PC(4'h0), .LAST_ADDR(4'h5), .HALT_EN(1'b1), .NOP_INST(16'h0000), .CNT_W(8)) u_last5 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_en_i(jen), .jump_addr_i(jaddr),
        .rom_addr_o(rom1), .rom_inst_i(rinst1), .inst_o(inst1), .inst_addr_o(addr1),
        .valid_o(val1), .halt_o(halt1), .fetch_cnt_o(cnt1)
    );

    if_stage #(.RESET_PC(4'h0), .LAST_ADDR(4'hF), .HALT_EN(1'b0), .NOP_INST(16'h0000), .CNT_W(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .jump_en_i(jen), .jump_addr_i(jaddr),
        .rom_addr_o(rom2), .rom_inst_i(rinst2), .inst_o(inst2), .inst_addr_o(addr2),
        .valid_o(val2), .halt_o(halt2), .fetch_cnt_o(cnt2)
    );

    typedef struct {
        int          cyc;   // edge number to check after; -1 = check immediately
        int          id;
        int          tnum;
        logic [3:0]  rom;
        logic [15:0] inst;
        logic [3:0]  addr;
        logic        valid;
        logic        halt;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    event chk_ev;

    function automatic void compare(exp_t e);
        logic [3:0]  r, a;
        logic [15:0] i;
        logic        v, h;
        logic [7:0]  c;
        case (e.id)
            0:       begin r = rom0; i = inst0; a = addr0; v = val0; h = halt0; c = cnt0; end
            1:       begin r = rom1; i = inst1; a = addr1; v = val1; h = halt1; c = cnt1; end
            default: begin r = rom2; i = inst2; a = addr2; v = val2; h = halt2; c = cnt2; end
        endcase
        checks++;
        if (r !== e.rom || i !== e.inst || a !== e.addr || v !== e.valid || h !== e.halt || c !== e.cnt) begin
            failures++;
            $display("FAIL T%0d_dut%0d cyc=%0d got rom=%h inst=%h addr=%h valid=%b halt=%b cnt=%0d required rom=%h inst=%h addr=%h valid=%b halt=%b cnt=%0d",
                     e.tnum, e.id, cyc, r, i, a, v, h, c, e.rom, e.inst, e.addr, e.valid, e.halt, e.cnt);
        end
    endfunction

    // Edge monitor: checks every expectation tagged with the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL T%0d_dut%0d missed expectation for edge %0d (now %0d)", e.tnum, e.id, e.cyc, cyc);
                end else begin
                    compare(e);
                end
            end
        end
    end

    // Immediate monitor for asynchronous reset checks between edges.
    initial begin
        forever begin
            @(chk_ev);
            while (sb.size() > 0 && sb[0].cyc < 0) compare(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic push(int c, int id, int t, logic [3:0] rom, logic [15:0] inst, logic [3:0] a,
                        logic v, logic h, logic [7:0] cn);
        exp_t e;
        e.cyc = c; e.id = id; e.tnum = t; e.rom = rom; e.inst = inst;
        e.addr = a; e.valid = v; e.halt = h; e.cnt = cn;
        sb.push_back(e);
    endtask

    // Called at a negedge: drive inputs, queue expected outputs after the next edge.
    task automatic step(logic s, logic j, logic [3:0] ja, int id, int t, logic [3:0] rom,
                        logic [15:0] inst, logic [3:0] a, logic v, logic h, logic [7:0] cn);
        stall = s;
        jen   = j;
        jaddr = ja;
        push(cyc + 1, id, t, rom, inst, a, v, h, cn);
        @(negedge clk);
    endtask

    task automatic apply_reset(int id, int t);
        rst_n = 1'b0;
        stall = 1'b0;
        jen   = 1'b0;
        #1;
        push(-1, id, t, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 8'd0);
        ->chk_ev;
        #1;
        push(cyc + 1, id, t, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 1'b0;
        jen   = 1'b0;
        jaddr = 4'h0;
        @(negedge clk);

        // T1: clean run from reset
        apply_reset(0, 1);
        step(1'b0, 1'b0, 4'h0, 0, 1, 4'h1, 16'hA000, 4'h0, 1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b0, 4'h0, 0, 1, 4'h2, 16'hA001, 4'h1, 1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b0, 4'h0, 0, 1, 4'h3, 16'hA002, 4'h2, 1'b1, 1'b0, 8'd3);
        step(1'b0, 1'b0, 4'h0, 0, 1, 4'h4, 16'hA003, 4'h3, 1'b1, 1'b0, 8'd4);

        // T6: reset asserted mid-run between edges
        apply_reset(0, 6);

        // T2: two stalled edges at pc=2
        step(1'b0, 1'b0, 4'h0, 0, 2, 4'h1, 16'hA000, 4'h0, 1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b0, 4'h0, 0, 2, 4'h2, 16'hA001, 4'h1, 1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 4'h0, 0, 2, 4'h2, 16'hA001, 4'h1, 1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 4'h0, 0, 2, 4'h2, 16'hA001, 4'h1, 1'b1, 1'b0, 8'd2);
        step(1'b0, 1'b0, 4'h0, 0, 2, 4'h3, 16'hA002, 4'h2, 1'b1, 1'b0, 8'd3);
        step(1'b0, 1'b0, 4'h0, 0, 2, 4'h4, 16'hA003, 4'h3, 1'b1, 1'b0, 8'd4);

        // T3: jump with stall at pc=4 -> bubble then target
        step(1'b1, 1'b1, 4'h9, 0, 3, 4'h9, 16'h0000, 4'h4, 1'b0, 1'b0, 8'd4);
        step(1'b0, 1'b0, 4'h0, 0, 3, 4'hA, 16'hA009, 4'h9, 1'b1, 1'b0, 8'd5);
        step(1'b0, 1'b0, 4'h0, 0, 3, 4'hB, 16'hA00A, 4'hA, 1'b1, 1'b0, 8'd6);

        // T4: LAST_ADDR=5 halt, stall in halt, jump out
        apply_reset(1, 4);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b0, 4'h0, 1, 4, 4'(k), 16'hA000 | 16'(k - 1), 4'(k - 1), 1'b1, 1'b0, 8'(k));
        end
        step(1'b0, 1'b0, 4'h0, 1, 4, 4'h5, 16'hA005, 4'h5, 1'b1, 1'b1, 8'd6);
        step(1'b0, 1'b0, 4'h0, 1, 4, 4'h5, 16'h0000, 4'h5, 1'b0, 1'b1, 8'd6);
        step(1'b0, 1'b0, 4'h0, 1, 4, 4'h5, 16'h0000, 4'h5, 1'b0, 1'b1, 8'd6);
        step(1'b1, 1'b0, 4'h0, 1, 4, 4'h5, 16'h0000, 4'h5, 1'b0, 1'b1, 8'd6);
        step(1'b0, 1'b1, 4'h2, 1, 4, 4'h2, 16'h0000, 4'h5, 1'b0, 1'b0, 8'd6);
        step(1'b0, 1'b0, 4'h0, 1, 4, 4'h3, 16'hA002, 4'h2, 1'b1, 1'b0, 8'd7);
        step(1'b0, 1'b0, 4'h0, 1, 4, 4'h4, 16'hA003, 4'h3, 1'b1, 1'b0, 8'd8);

        // T5: HALT_EN=0, 300 edges: PC wrap and counter saturation
        apply_reset(2, 5);
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, 1'b0, 4'h0, 2, 5, 4'(k % 16), 16'hA000 | 16'((k - 1) % 16), 4'((k - 1) % 16),
                 1'b1, 1'b0, 8'((k > 255) ? 255 : k));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain got %0d pending entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
